nrd_seq: RTL and testbench

Parametrised, iterative non-restoring unsigned divider that produces one quotient bit per clock. It replaces the fixed-width 24-bit combinational and pipelined dividers where area matters more than throughput. A start/busy/done handshake makes it usable from any controlling FSM. It also detects divide-by-zero, which the earlier dividers did not handle.

---
 rtl/nrd_seq.sv | 107 ++++++++++
 tb/tb_nrd_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nrd_seq.sv
// Iterative non-restoring unsigned divider: one quotient bit per clock,
// start/busy/done handshake and divide-by-zero detection.
module nrd_seq #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         dbz
);

    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dq;
    logic [W-1:0]  bq;
    logic [W:0]    p;
    logic [W:0]    p_shift;
    logic [W:0]    p_step;
    logic [W-1:0]  rem_fix;
    logic          last_iter;
    logic          accept;

    // One non-restoring step; P stays within [-B, B) so W+1 bits suffice
    // even though the shifted intermediate may wrap.
    always_comb begin
        p_shift   = {p[W-1:0], dq[W-1]};
        p_step    = p[W] ? (p_shift + {1'b0, bq}) : (p_shift - {1'b0, bq});
        rem_fix   = p[W] ? (p[W-1:0] + bq) : p[W-1:0];
        last_iter = (cnt == CW'(W - 1));
        accept    = start && (b != '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last_iter) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dq   <= '0;
            bq   <= '0;
            p    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            quo  <= '0;
            rem  <= '0;
            dbz  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dq   <= a;
                        bq   <= b;
                        p    <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
                        dbz  <= 1'b0;
                    end else if (start) begin
                        quo  <= '1;
                        rem  <= a;
                        dbz  <= 1'b1;
                        done <= 1'b1;
                    end
                end
                S_RUN: begin
                    p   <= p_step;
                    dq  <= {dq[W-2:0], ~p_step[W]};
                    cnt <= cnt + CW'(1);
                end
                S_FIX: begin
                    quo  <= dq;
                    rem  <= rem_fix;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nrd_seq.sv
// Bench for nrd_seq: W=24 directed vectors checked against a transaction
// model every cycle, plus a W=8 back-to-back sweep against a/b and a%b.
module tb_nrd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        armed = 1'b0;

    logic        start24 = 1'b0;
    logic [23:0] a24 = '0;
    logic [23:0] b24 = '0;
    logic        busy24, done24, dbz24;
    logic [23:0] quo24, rem24;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  quo8, rem8;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    nrd_seq #(.W(24)) u24 (
        .clk(clk), .rst(rst), .start(start24), .a(a24), .b(b24),
        .busy(busy24), .done(done24), .quo(quo24), .rem(rem24), .dbz(dbz24)
    );

    nrd_seq #(.W(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .quo(quo8), .rem(rem8), .dbz(dbz8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the W=24 instance: a countdown of W+1 edges
    // per accepted division, results from plain / and %.
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [23:0] m_quo = '0, m_rem = '0, m_a = '0, m_b = '1;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_quo  <= '0;   m_rem  <= '0;   m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_quo  <= m_a / m_b;
                    m_rem  <= m_a % m_b;
                end
            end else if (start24) begin
                if (b24 == 24'd0) begin
                    m_quo <= 24'hFFFFFF; m_rem <= a24; m_dbz <= 1'b1; m_done <= 1'b1;
                end else begin
                    m_a <= a24; m_b <= b24; m_busy <= 1'b1; m_dbz <= 1'b0; m_left <= 25;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cyc_busy", 32'(busy24), 32'(m_busy));
            check("cyc_done", 32'(done24), 32'(m_done));
            check("cyc_dbz",  32'(dbz24),  32'(m_dbz));
            check("cyc_quo",  32'(quo24),  32'(m_quo));
            check("cyc_rem",  32'(rem24),  32'(m_rem));
        end
    end

    // Drive start for one cycle; returns at the negedge after the accepting edge.
    task automatic go24(input logic [23:0] av, input logic [23:0] bv);
        start24 = 1'b1; a24 = av; b24 = bv;
        @(negedge clk);
        start24 = 1'b0; a24 = 24'($urandom); b24 = 24'($urandom);
    endtask

    // k counts edges after the accepting edge; bounded wait for done.
    task automatic wait_done24(input int k0, output int k);
        k = k0;
        while (done24 !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("done24_seen", 32'(done24), 32'd1);
    endtask

    task automatic run24(input string name, input logic [23:0] av, input logic [23:0] bv,
                         input logic [23:0] eq, input logic [23:0] er,
                         input logic edbz, input int elat);
        int k;
        go24(av, bv);
        wait_done24(0, k);
        check({name, "_lat"}, 32'(k), 32'(elat));
        check({name, "_quo"}, 32'(quo24), 32'(eq));
        check({name, "_rem"}, 32'(rem24), 32'(er));
        check({name, "_dbz"}, 32'(dbz24), 32'(edbz));
    endtask

    initial begin
        int k;
        int seen;

        // Reset with start held: reset wins
        start24 = 1'b1; a24 = 24'd50; b24 = 24'd4;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy24), 32'd0);
        check("rst_done", 32'(done24), 32'd0);
        check("rst_quo",  32'(quo24),  32'd0);
        check("rst_rem",  32'(rem24),  32'd0);
        check("rst_dbz",  32'(dbz24),  32'd0);
        start24 = 1'b0;
        rst = 1'b0;
        armed = 1'b1;
        @(negedge clk);

        run24("d50_4", 24'd50, 24'd4, 24'd12, 24'd2, 1'b0, 25);
        run24("d40_3_b2b", 24'd40, 24'd3, 24'd13, 24'd1, 1'b0, 25);
        run24("d8001ff", 24'h8001FF, 24'd2, 24'h4000FF, 24'd1, 1'b0, 25);
        run24("daa4000", 24'hAA4000, 24'h0A0000, 24'd17, 24'h004000, 1'b0, 25);
        run24("dffffff", 24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0, 1'b0, 25);
        run24("d5_9", 24'd5, 24'd9, 24'd0, 24'd5, 1'b0, 25);
        @(negedge clk);

        run24("dbz", 24'd40, 24'd0, 24'hFFFFFF, 24'd40, 1'b1, 0);
        check("dbz_busy", 32'(busy24), 32'd0);
        @(negedge clk);
        run24("after_dbz", 24'd9, 24'd3, 24'd3, 24'd0, 1'b0, 25);
        @(negedge clk);

        // Start pulse while busy is ignored
        go24(24'd40, 24'd2);
        repeat (9) @(negedge clk);
        start24 = 1'b1; a24 = 24'd7; b24 = 24'd7;
        @(negedge clk);
        start24 = 1'b0;
        check("ign_busy", 32'(busy24), 32'd1);
        wait_done24(10, k);
        check("ign_lat", 32'(k), 32'd25);
        check("ign_quo", 32'(quo24), 32'd20);
        check("ign_rem", 32'(rem24), 32'd0);
        @(negedge clk);

        // Reset mid-run aborts with no done
        go24(24'd50, 24'd4);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy24), 32'd0);
        check("abort_quo",  32'(quo24),  32'd0);
        check("abort_rem",  32'(rem24),  32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done24 === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // W=8 back-to-back sweep
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] av;
            logic [7:0] bv;
            av = 8'($urandom);
            bv = 8'($urandom);
            if (i == 0) bv = 8'd0;
            if (i == 1) begin av = 8'd255; bv = 8'd1; end
            start8 = 1'b1; a8 = av; b8 = bv;
            @(negedge clk);
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            k = 0;
            while (done8 !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("w8_done_seen", 32'(done8), 32'd1);
            if (bv == 8'd0) begin
                check("w8_dbz_lat", 32'(k), 32'd0);
                check("w8_dbz_flag", 32'(dbz8), 32'd1);
                check("w8_dbz_quo", 32'(quo8), 32'hFF);
                check("w8_dbz_rem", 32'(rem8), 32'(av));
            end else begin
                check("w8_lat", 32'(k), 32'd9);
                check("w8_quo", 32'(quo8), 32'(av / bv));
                check("w8_rem", 32'(rem8), 32'(av % bv));
                check("w8_ident", 32'((int'(quo8) * int'(bv) + int'(rem8) == int'(av)) && (rem8 < bv)), 32'd1);
                check("w8_dbz", 32'(dbz8), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
